mem_access_stage: RTL and testbench

Pipeline MEM stage between the EX/MEM register and the MEM/WB register. It passes ALU results through for non-memory instructions. For loads and stores it runs a req/ack transaction on the data-memory bus, stalling the front of the pipeline until the transaction completes. It presents `alu_out`, `reg_dst`, `reg_wr` and `wb_sel` to the MEM/WB register, with load data substituted into `alu_out`. A bus timeout produces a flagged, non-writing result instead of hanging the core.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mem_access_stage.sv | 141 ++++++++++++++
 tb/tb_mem_access_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline stages.
package cpu_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: passes ALU results through and runs req/ack data-memory
// transactions for loads/stores, stalling the front end until they complete.
//
// state | meaning
// IDLE  | pass-through; a non-flushed load/store launches a bus request
// WAIT  | request outstanding, bus fields held; ack or timeout ends it
// DONE  | one cycle presenting the load data / store result to MEM/WB
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          store_data_i,
  input  logic [REG_IDX_W-1:0] reg_dst_i,
  input  logic                 mem_rd_i,
  input  logic                 mem_wr_i,
  input  logic                 reg_wr_i,
  input  logic                 wb_sel_i,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  input  logic [31:0]          dmem_rdata,
  output logic [31:0]          alu_out_o,
  output logic [REG_IDX_W-1:0] reg_dst_o,
  output logic                 reg_wr_o,
  output logic                 wb_sel_o,
  output logic                 stall_req,
  output logic                 bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_kill;
  logic        r_is_load;
  logic [31:0] r_rdata_q;
  logic        w_start;
  logic        w_ack;
  logic        w_timeout;

  assign w_start   = (r_state == IDLE) & (mem_rd_i | mem_wr_i) & ~flush;
  assign w_ack     = (r_state == WAIT) & dmem_req & dmem_ack;
  // Ack wins over timeout when both land in the same cycle.
  assign w_timeout = (r_state == WAIT) & ~w_ack & (r_cnt == TO_LAST);

  assign reg_dst_o = reg_dst_i;
  assign wb_sel_o  = wb_sel_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = WAIT;
      WAIT:    if (w_ack || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_out_o = alu_result_i;
    reg_wr_o  = reg_wr_i & ~flush;
    stall_req = 1'b0;
    bus_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          stall_req = 1'b1;
          reg_wr_o  = 1'b0;
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        reg_wr_o  = 1'b0;
        bus_err   = w_timeout;
      end
      DONE: begin
        if (r_is_load) alu_out_o = r_rdata_q;
        reg_wr_o = reg_wr_i & ~r_kill & ~flush;
      end
      default: ;
    endcase
    if (rst) begin
      stall_req = 1'b0;
      reg_wr_o  = 1'b0;
      bus_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      r_rdata_q  <= '0;
      r_kill     <= 1'b0;
      r_is_load  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_wr_i;
            dmem_addr  <= alu_result_i;
            dmem_wdata <= store_data_i;
            r_is_load  <= ~mem_wr_i;
            r_cnt      <= '0;
            r_kill     <= 1'b0;
          end
        end
        WAIT: begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          if (flush) r_kill <= 1'b1;
          if (w_ack) begin
            r_rdata_q <= dmem_rdata;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata_q <= BUS_ERR_DATA;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            r_kill    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through vector table plus
// hand-written load/store/flush/timeout/reset transaction sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [3:0]  reg_dst_i;
  logic        mem_rd_i, mem_wr_i, reg_wr_i, wb_sel_i;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] alu_out_o;
  logic [3:0]  reg_dst_o;
  logic        reg_wr_o, wb_sel_o, stall_req, bus_err;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .reg_dst_i(reg_dst_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .reg_wr_i(reg_wr_i), .wb_sel_i(wb_sel_i),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_out_o(alu_out_o), .reg_dst_o(reg_dst_o), .reg_wr_o(reg_wr_o),
    .wb_sel_o(wb_sel_o), .stall_req(stall_req), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [3:0]  dst;
    logic        rd, wr, rw, wb, fl;
    logic [31:0] e_alu;
    logic        e_rw;
  } vec_t;

  vec_t vecs[6];

  int          res_stall, res_req, res_berr, res_cycle;
  logic [31:0] res_alu;
  logic        res_rw, res_bus_ok, res_bubble_ok, res_done;

  // Launch one load/store; ack arrives in req cycle k (k<0: never).
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int k, input logic [31:0] rd, input logic fl_wait,
                     input logic rw_in);
    int cycle;
    int req_idx;
    @(posedge clk); #1;
    alu_result_i = addr; store_data_i = wdata; reg_dst_i = 4'd9;
    mem_rd_i = ~wr; mem_wr_i = wr; reg_wr_i = rw_in; wb_sel_i = ~wr;
    flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    res_stall = 0; res_req = 0; res_berr = 0; res_cycle = -1;
    res_alu = '0; res_rw = 1'bx; res_bus_ok = 1'b1; res_bubble_ok = 1'b1; res_done = 1'b0;
    cycle = 0; req_idx = 0;
    while (!res_done && cycle < 40) begin
      if (dmem_req && req_idx == k) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
      end
      flush = fl_wait && dmem_req && req_idx == 1;
      @(negedge clk);
      if (stall_req) begin
        res_stall++;
        if (reg_wr_o) res_bubble_ok = 1'b0;
      end
      if (bus_err) res_berr++;
      if (dmem_req) begin
        res_req++;
        if (dmem_addr !== addr || dmem_wdata !== wdata || dmem_we !== wr) res_bus_ok = 1'b0;
        req_idx++;
      end
      if (!stall_req && cycle > 0) begin
        res_done = 1'b1; res_cycle = cycle; res_alu = alu_out_o; res_rw = reg_wr_o;
      end
      @(posedge clk); #1;
      cycle++;
    end
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; flush = 1'b0; dmem_ack = 1'b0;
    chk("txn_bound", {31'd0, res_done}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 1'b1};
    vecs[1] = '{32'hA5A5_0000, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0000, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{32'h0000_0040, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0};
    vecs[4] = '{32'h0000_0080, 4'd7,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0};
    vecs[5] = '{32'h0000_0000, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

    rst = 1'b1; flush = 1'b0; alu_result_i = 32'h1; store_data_i = 32'h2;
    reg_dst_i = 4'd1; mem_rd_i = 1'b0; mem_wr_i = 1'b0; reg_wr_i = 1'b1;
    wb_sel_i = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_reg_wr", {31'd0, reg_wr_o}, 32'd0);
    chk("rst_req", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Pass-through vectors; a stray ack must not start anything.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      alu_result_i = vecs[i].alu; store_data_i = 32'h5555_0000; reg_dst_i = vecs[i].dst;
      mem_rd_i = vecs[i].rd; mem_wr_i = vecs[i].wr; reg_wr_i = vecs[i].rw;
      wb_sel_i = vecs[i].wb; flush = vecs[i].fl; dmem_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_alu", i), alu_out_o, vecs[i].e_alu);
      chk($sformatf("vec%0d_reg_wr", i), {31'd0, reg_wr_o}, {31'd0, vecs[i].e_rw});
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_req}, 32'd0);
      chk($sformatf("vec%0d_req", i), {31'd0, dmem_req}, 32'd0);
      chk($sformatf("vec%0d_dst_wb", i), {27'd0, reg_dst_o, wb_sel_o}, {27'd0, vecs[i].dst, vecs[i].wb});
    end
    @(posedge clk); #1;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; flush = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    chk("vec_end_req", {31'd0, dmem_req}, 32'd0);

    // Load, ack three cycles after req rises.
    txn(1'b0, 32'h40, 32'h0, 3, 32'hCAFE_0001, 1'b0, 1'b1);
    chk("ld3_stall", res_stall, 5);
    chk("ld3_req", res_req, 4);
    chk("ld3_cycle", res_cycle, 5);
    chk("ld3_alu", res_alu, 32'hCAFE_0001);
    chk("ld3_rw", {31'd0, res_rw}, 32'd1);
    chk("ld3_bus", {31'd0, res_bus_ok}, 32'd1);
    chk("ld3_bubble", {31'd0, res_bubble_ok}, 32'd1);
    chk("ld3_berr", res_berr, 0);

    // Store, ack in first req cycle.
    txn(1'b1, 32'h80, 32'h55, 0, 32'h0, 1'b0, 1'b1);
    chk("st0_stall", res_stall, 2);
    chk("st0_req", res_req, 1);
    chk("st0_alu", res_alu, 32'h80);
    chk("st0_rw", {31'd0, res_rw}, 32'd1);
    chk("st0_bus", {31'd0, res_bus_ok}, 32'd1);

    txn(1'b1, 32'h84, 32'h66, 1, 32'h0, 1'b0, 1'b0);
    chk("st1_stall", res_stall, 3);
    chk("st1_req", res_req, 2);
    chk("st1_rw", {31'd0, res_rw}, 32'd0);

    // Load flushed while waiting: bus finishes, writeback suppressed.
    txn(1'b0, 32'h44, 32'h0, 2, 32'h1357_2468, 1'b1, 1'b1);
    chk("ldfl_req", res_req, 3);
    chk("ldfl_alu", res_alu, 32'h1357_2468);
    chk("ldfl_rw", {31'd0, res_rw}, 32'd0);
    chk("ldfl_bus", {31'd0, res_bus_ok}, 32'd1);

    // Load with no ack: TIMEOUT=4 gives four WAIT cycles.
    txn(1'b0, 32'h48, 32'h0, -1, 32'h0, 1'b0, 1'b1);
    chk("to_req", res_req, 4);
    chk("to_stall", res_stall, 5);
    chk("to_berr", res_berr, 1);
    chk("to_alu", res_alu, 32'hDEAD_BEEF);
    chk("to_rw", {31'd0, res_rw}, 32'd0);

    // A load right after timeout must complete normally with write enabled.
    txn(1'b0, 32'h4C, 32'h0, 1, 32'h0000_0ABC, 1'b0, 1'b1);
    chk("ld1_alu", res_alu, 32'h0000_0ABC);
    chk("ld1_rw", {31'd0, res_rw}, 32'd1);

    // Reset during WAIT, then a late ack.
    @(posedge clk); #1;
    alu_result_i = 32'h100; mem_rd_i = 1'b1; reg_wr_i = 1'b1; dmem_ack = 1'b0;
    @(posedge clk); #1;
    mem_rd_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_pre_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rw_rst_regwr", {31'd0, reg_wr_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111; alu_result_i = 32'h77;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("late%0d_req", i), {31'd0, dmem_req}, 32'd0);
      chk($sformatf("late%0d_stall", i), {31'd0, stall_req}, 32'd0);
      chk($sformatf("late%0d_alu", i), alu_out_o, 32'h77);
      chk($sformatf("late%0d_rw", i), {31'd0, reg_wr_o}, 32'd1);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
